// File: rtl/bus_host_arbiter_pkg.sv
// Shared types and width helpers for the bus host arbiter and its ID FIFO.
package bus_arb_pkg;

    localparam int unsigned NrHostsDefault = 2;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned HostIdxW = idx_width(NrHostsDefault);

    typedef logic [HostIdxW-1:0] host_idx_t;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_host_arbiter_if.sv
// Host-side and device-side bus signals of the arbiter, bundled per direction.
interface bus_host_arbiter_if #(
    parameter int unsigned NrHosts      = 2,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
);

    logic                      host_req_i    [NrHosts];
    logic                      host_gnt_o    [NrHosts];
    logic [AddressWidth-1:0]   host_addr_i   [NrHosts];
    logic                      host_we_i     [NrHosts];
    logic [DataWidth/8-1:0]    host_be_i     [NrHosts];
    logic [DataWidth-1:0]      host_wdata_i  [NrHosts];
    logic                      host_rvalid_o [NrHosts];
    logic [DataWidth-1:0]      host_rdata_o  [NrHosts];
    logic                      host_err_o    [NrHosts];

    logic                      dev_req_o;
    logic                      dev_gnt_i;
    logic [AddressWidth-1:0]   dev_addr_o;
    logic                      dev_we_o;
    logic [DataWidth/8-1:0]    dev_be_o;
    logic [DataWidth-1:0]      dev_wdata_o;
    logic                      dev_rvalid_i;
    logic [DataWidth-1:0]      dev_rdata_i;
    logic                      dev_err_i;

    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i
    );

endinterface

// File: rtl/bus_host_arbiter_id_fifo.sv
// In-order FIFO of granted host indices; the head names the owner of the next response.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = HostIdxW
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned     PtrW     = idx_width(Depth);
    localparam int unsigned     CntW     = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == DepthCnt);
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];

    // Overflow and underflow requests are ignored so the pointers never corrupt.
    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one bus host port among several hosts; responses are
// routed back in order through an ID FIFO.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    bus_host_arbiter_if.slave bus
);

    localparam int unsigned IdxW = idx_width(NrHosts);

    typedef logic [IdxW-1:0] idx_t;

    localparam idx_t LastIdx = idx_t'(NrHosts - 1);

    arb_state_e  r_state;
    arb_state_e  w_state_nxt;
    idx_t        r_prio;
    idx_t        w_prio_nxt;
    idx_t        r_lock_idx;
    idx_t        w_lock_idx_nxt;
    idx_t        w_rr_sel;
    idx_t        w_cand;
    idx_t        w_sel;
    idx_t        w_fld;
    idx_t        w_head;
    int unsigned w_pos;
    logic        w_any_req;
    logic        w_lock_hold;
    logic        w_req;
    logic        w_grant;
    logic        w_resp;
    logic        w_full;
    logic        w_empty;

    // Scan from the highest offset down so the lowest offset from r_prio wins.
    always_comb begin : rr_scan
        w_any_req = 1'b0;
        w_rr_sel  = '0;
        w_cand    = '0;
        w_pos     = 0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            w_any_req = w_any_req | bus.host_req_i[idx_t'(h)];
        end
        for (int unsigned k = NrHosts; k > 0; k--) begin
            w_pos = 32'(r_prio) + k - 1;
            if (w_pos >= NrHosts) begin
                w_pos = w_pos - NrHosts;
            end
            w_cand = idx_t'(w_pos);
            if (bus.host_req_i[w_cand]) begin
                w_rr_sel = w_cand;
            end
        end
    end

    // A stalled request keeps its host until granted, unless that host withdraws.
    assign w_lock_hold = (r_state == ARB_LOCKED) && bus.host_req_i[r_lock_idx];
    assign w_sel       = w_lock_hold ? r_lock_idx : w_rr_sel;

    assign w_req   = rst_ni & w_any_req & ~w_full;
    assign w_grant = w_req & bus.dev_gnt_i;
    assign w_resp  = rst_ni & bus.dev_rvalid_i & ~w_empty;
    assign w_fld   = w_req ? w_sel : '0;

    always_comb begin : out_mux
        for (int unsigned h = 0; h < NrHosts; h++) begin
            bus.host_gnt_o[idx_t'(h)]    = w_grant && (w_sel == idx_t'(h));
            bus.host_rvalid_o[idx_t'(h)] = w_resp && (w_head == idx_t'(h));
            bus.host_rdata_o[idx_t'(h)]  = bus.dev_rdata_i;
            bus.host_err_o[idx_t'(h)]    = bus.dev_err_i;
        end
        bus.dev_req_o   = w_req;
        bus.dev_addr_o  = bus.host_addr_i[w_fld];
        bus.dev_we_o    = bus.host_we_i[w_fld];
        bus.dev_be_o    = bus.host_be_i[w_fld];
        bus.dev_wdata_o = bus.host_wdata_i[w_fld];
    end

    always_comb begin : arb_fsm
        w_state_nxt    = ARB_FREE;
        w_lock_idx_nxt = r_lock_idx;
        w_prio_nxt     = r_prio;
        if (w_req && !bus.dev_gnt_i) begin
            w_state_nxt    = ARB_LOCKED;
            w_lock_idx_nxt = w_sel;
        end
        if (w_grant) begin
            w_prio_nxt = (w_sel == LastIdx) ? '0 : w_sel + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_FREE;
            r_lock_idx <= '0;
            r_prio     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock_idx <= w_lock_idx_nxt;
            r_prio     <= w_prio_nxt;
        end
    end

    bus_arb_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_grant),
        .pop_i   (w_resp),
        .data_i  (w_sel),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter with two hosts and two outstanding IDs.
module tb_bus_host_arbiter;

    logic clk_i;
    logic rst_ni;
    int   n_vec;
    int   n_err;

    bus_host_arbiter_if #(
        .NrHosts      (2),
        .DataWidth    (32),
        .AddressWidth (32)
    ) bus_if ();

    bus_host_arbiter #(
        .NrHosts        (2),
        .DataWidth      (32),
        .AddressWidth   (32),
        .MaxOutstanding (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_if)
    );

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic [1:0] w_rvalid;
    assign w_req    = {bus_if.host_req_i[1], bus_if.host_req_i[0]};
    assign w_gnt    = {bus_if.host_gnt_o[1], bus_if.host_gnt_o[0]};
    assign w_rvalid = {bus_if.host_rvalid_o[1], bus_if.host_rvalid_o[0]};

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hosts must keep requesting while their request is stalled on the bus.
    logic       r_prev_stall;
    logic [1:0] r_prev_req;
    always @(negedge clk_i) begin
        if (rst_ni && r_prev_stall) begin
            assert ((w_req & r_prev_req) == r_prev_req)
            else $error("host withdrew a stalled request");
        end
        r_prev_stall <= rst_ni & bus_if.dev_req_o & ~bus_if.dev_gnt_i;
        r_prev_req   <= w_req;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
        bus_if.host_req_i[0] = req[0];
        bus_if.host_req_i[1] = req[1];
        bus_if.dev_gnt_i     = gnt;
        bus_if.dev_rvalid_i  = rv;
        bus_if.dev_rdata_i   = rdata;
        bus_if.dev_err_i     = err;
        #1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        r_prev_stall = 1'b0;
        r_prev_req   = 2'b00;
        rst_ni       = 1'b0;
        bus_if.host_addr_i[0]  = 32'h0000_A000;
        bus_if.host_addr_i[1]  = 32'h0000_B000;
        bus_if.host_we_i[0]    = 1'b1;
        bus_if.host_we_i[1]    = 1'b0;
        bus_if.host_be_i[0]    = 4'hF;
        bus_if.host_be_i[1]    = 4'h3;
        bus_if.host_wdata_i[0] = 32'h1111_1111;
        bus_if.host_wdata_i[1] = 32'h2222_2222;

        // Outputs held quiet in reset even with every input active.
        cyc(2'b11, 1'b1, 1'b1, 32'h0, 1'b0);
        #1;
        chk("rst_req", 64'(bus_if.dev_req_o), 64'h0);
        chk("rst_gnt", 64'(w_gnt), 64'h0);
        chk("rst_rvalid", 64'(w_rvalid), 64'h0);
        tick();
        tick();
        rst_ni = 1'b1;

        // Single host, four back-to-back reads with one-cycle response latency.
        for (int k = 0; k < 4; k++) begin
            bus_if.host_addr_i[0] = 32'h0000_1000 + 32'(4 * k);
            cyc(2'b01, 1'b1, (k > 0), 32'h0, 1'b0);
            chk("b2b_req", 64'(bus_if.dev_req_o), 64'h1);
            chk("b2b_gnt", 64'(w_gnt), 64'h1);
            chk("b2b_addr", 64'(bus_if.dev_addr_o), 64'h1000 + 64'(4 * k));
            chk("b2b_rvalid", 64'(w_rvalid), (k > 0) ? 64'h1 : 64'h0);
            tick();
        end
        bus_if.host_addr_i[0] = 32'h0000_A000;
        cyc(2'b00, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("b2b_last_req", 64'(bus_if.dev_req_o), 64'h0);
        chk("b2b_last_rvalid", 64'(w_rvalid), 64'h1);
        tick();

        // Priority is 1 here: only host 0 requests, scan wraps to it.
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("wrap_gnt", 64'(w_gnt), 64'h1);
        tick();

        // Both hosts contend; grants alternate starting at host 1 (priority stays 1).
        for (int k = 0; k < 4; k++) begin
            cyc(2'b11, 1'b1, 1'b1, 32'h0, 1'b0);
            chk("fair_gnt", 64'(w_gnt), (k % 2 == 0) ? 64'h2 : 64'h1);
            chk("fair_rvalid", 64'(w_rvalid), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
        end
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("fair_drain", 64'(w_rvalid), 64'h1);
        tick();

        // Grant host 1 once so priority returns to host 0 before the lock test.
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("pre_gnt", 64'(w_gnt), 64'h2);
        tick();
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("pre_rvalid", 64'(w_rvalid), 64'h2);
        tick();

        // Host 1 stalls for three cycles; host 0 joins but must not steal the bus.
        for (int k = 0; k < 3; k++) begin
            cyc((k == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("lock_addr", 64'(bus_if.dev_addr_o), 64'hB000);
            chk("lock_gnt", 64'(w_gnt), 64'h0);
            tick();
        end
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("lock_wdata", 64'(bus_if.dev_wdata_o), 64'h2222_2222);
        chk("lock_be", 64'(bus_if.dev_be_o), 64'h3);
        chk("lock_we", 64'(bus_if.dev_we_o), 64'h0);
        chk("lock_gnt_final", 64'(w_gnt), 64'h2);
        tick();
        cyc(2'b11, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("after_lock_gnt", 64'(w_gnt), 64'h1);
        chk("after_lock_addr", 64'(bus_if.dev_addr_o), 64'hA000);
        chk("after_lock_rvalid", 64'(w_rvalid), 64'h2);
        tick();
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("after_lock_drain", 64'(w_rvalid), 64'h1);
        tick();

        // Fill both slots, then drain one response at a time.
        cyc(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_g0", 64'(w_gnt), 64'h1);
        tick();
        cyc(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_g1", 64'(w_gnt), 64'h2);
        tick();
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_req", 64'(bus_if.dev_req_o), 64'h0);
        chk("full_gnt", 64'(w_gnt), 64'h0);
        chk("full_idle_addr", 64'(bus_if.dev_addr_o), 64'hA000);
        tick();
        cyc(2'b11, 1'b1, 1'b1, 32'hDEAD_0001, 1'b0);
        chk("full_pop_req", 64'(bus_if.dev_req_o), 64'h0);
        chk("full_pop_rvalid", 64'(w_rvalid), 64'h1);
        chk("full_rdata", 64'(bus_if.host_rdata_o[1]), 64'hDEAD_0001);
        tick();
        cyc(2'b11, 1'b1, 1'b1, 32'h0, 1'b1);
        chk("pushpop_req", 64'(bus_if.dev_req_o), 64'h1);
        chk("pushpop_gnt", 64'(w_gnt), 64'h1);
        chk("err_rvalid", 64'(w_rvalid), 64'h2);
        chk("err_flag", 64'(bus_if.host_err_o[1]), 64'h1);
        tick();
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("count1_req", 64'(bus_if.dev_req_o), 64'h1);
        chk("count1_gnt", 64'(w_gnt), 64'h2);
        tick();
        cyc(2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();

        // Reset with two IDs outstanding discards them.
        rst_ni = 1'b0;
        cyc(2'b11, 1'b1, 1'b1, 32'h0, 1'b0);
        chk("mid_rst_req", 64'(bus_if.dev_req_o), 64'h0);
        chk("mid_rst_gnt", 64'(w_gnt), 64'h0);
        chk("mid_rst_rvalid", 64'(w_rvalid), 64'h0);
        tick();
        rst_ni = 1'b1;
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("stray_rvalid", 64'(w_rvalid), 64'h0);
        tick();
        cyc(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("post_rst_req", 64'(bus_if.dev_req_o), 64'h1);
        chk("post_rst_gnt", 64'(w_gnt), 64'h1);
        tick();
        cyc(2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("post_rst_rvalid", 64'(w_rvalid), 64'h1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
